// File: rtl/dr_edit_ctrl_if.sv
// Board-side bundle for the DR edit sequencer: raw button/switch levels going
// in, DR op codes and register-file addressing coming out.
interface dr_edit_ctrl_if #(
    parameter int AW = 3
);
    logic          btn_digit;
    logic [3:0]    digit;
    logic          btn_del;
    logic          btn_wb;
    logic          btn_up;
    logic          btn_down;
    logic [3:0]    state;
    logic [3:0]    rd0;
    logic [AW-1:0] ra;
    logic          we;
    logic [2:0]    cnt;
    logic          busy;

    // Board I/O side: drives the raw inputs, observes the sequencer outputs.
    modport master (
        output btn_digit, digit, btn_del, btn_wb, btn_up, btn_down,
        input  state, rd0, ra, we, cnt, busy
    );

    // Sequencer side.
    modport slave (
        input  btn_digit, digit, btn_del, btn_wb, btn_up, btn_down,
        output state, rd0, ra, we, cnt, busy
    );
endinterface

// File: rtl/dr_edit_ctrl.sv
// DR / register-file edit sequencer. Raw buttons are synchronized and
// edge-detected; an edge seen while idle becomes exactly one one-cycle DR op
// code. All outputs are registered and decoded from the FSM state, so an input
// rising before posedge k shows its op code after posedge k+3.
module dr_edit_ctrl #(
    parameter int AW   = 3,
    parameter int NDIG = 4
) (
    input  logic           clk,
    input  logic           rstn,
    dr_edit_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_LOAD      = 3'd2,
        S_WRITE     = 3'd3,
        S_SHIFT_IN  = 3'd4,
        S_SHIFT_OUT = 3'd5,
        S_ADDR      = 3'd6
    } fsm_t;

    // Bit positions in the packed button vector, highest index = highest priority.
    localparam int B_DIG  = 0;
    localparam int B_DEL  = 1;
    localparam int B_DOWN = 2;
    localparam int B_UP   = 3;
    localparam int B_WB   = 4;

    localparam logic [2:0] CNT_MAX = 3'(NDIG);

    localparam logic [3:0] OP_HOLD  = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_WRITE = 4'd2;
    localparam logic [3:0] OP_SIN   = 4'd3;
    localparam logic [3:0] OP_SOUT  = 4'd4;
    localparam logic [3:0] OP_ADDR  = 4'd5;

    // Input conditioning flops
    logic [4:0]    btn_s1_q, btn_s1_d;
    logic [4:0]    btn_s2_q, btn_s2_d;
    logic [4:0]    btn_prev_q, btn_prev_d;
    logic [3:0]    dig_s1_q, dig_s1_d;
    logic [3:0]    dig_s2_q, dig_s2_d;
    logic [4:0]    edge_det;

    // Control flops
    fsm_t          fsm_q, fsm_d;
    logic          dir_up_q, dir_up_d;

    // Registered outputs
    logic [3:0]    state_q, state_d;
    logic [3:0]    rd0_q, rd0_d;
    logic [AW-1:0] ra_q, ra_d;
    logic          we_q, we_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d;

    // Two-stage synchronizers plus previous-value register for edge detection.
    always_comb begin
        btn_s1_d   = {bus.btn_wb, bus.btn_up, bus.btn_down, bus.btn_del, bus.btn_digit};
        btn_s2_d   = btn_s1_q;
        btn_prev_d = btn_s2_q;
        dig_s1_d   = bus.digit;
        dig_s2_d   = dig_s1_q;
        edge_det   = btn_s2_q & ~btn_prev_q;
    end

    // Next-state selection; edges are only consumed when fully idle, otherwise
    // they vanish with their one-cycle pulse and are never queued.
    always_comb begin
        fsm_d    = fsm_q;
        dir_up_d = dir_up_q;
        case (fsm_q)
            S_INIT: fsm_d = S_LOAD;
            S_IDLE: begin
                if (!busy_q) begin
                    if (edge_det[B_WB]) begin
                        fsm_d = S_WRITE;
                    end else if (edge_det[B_UP]) begin
                        fsm_d    = S_ADDR;
                        dir_up_d = 1'b1;
                    end else if (edge_det[B_DOWN]) begin
                        fsm_d    = S_ADDR;
                        dir_up_d = 1'b0;
                    end else if (edge_det[B_DEL]) begin
                        // Backspace on an empty DR issues nothing.
                        fsm_d = (cnt_q != 3'd0) ? S_SHIFT_OUT : S_IDLE;
                    end else if (edge_det[B_DIG]) begin
                        fsm_d = S_SHIFT_IN;
                    end
                end
            end
            S_ADDR:  fsm_d = S_LOAD;
            default: fsm_d = S_IDLE;
        endcase
    end

    // Output decode: each op state yields its code for exactly one cycle, and
    // the address changes on the ADDR edge so LOAD sees the new ra.
    always_comb begin
        state_d = OP_HOLD;
        we_d    = 1'b0;
        busy_d  = (fsm_q != S_IDLE);
        rd0_d   = rd0_q;
        ra_d    = ra_q;
        cnt_d   = cnt_q;
        case (fsm_q)
            S_LOAD: begin
                state_d = OP_LOAD;
                cnt_d   = CNT_MAX;
            end
            S_WRITE: begin
                state_d = OP_WRITE;
                we_d    = 1'b1;
            end
            S_SHIFT_IN: begin
                state_d = OP_SIN;
                rd0_d   = dig_s2_q;
                cnt_d   = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 3'd1;
            end
            S_SHIFT_OUT: begin
                state_d = OP_SOUT;
                cnt_d   = cnt_q - 3'd1;
            end
            S_ADDR: begin
                state_d = OP_ADDR;
                ra_d    = dir_up_q ? ra_q + AW'(1) : ra_q - AW'(1);
            end
            default: ;
        endcase
    end

    // All state; reset abandons any op in flight and restarts with INIT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            btn_prev_q <= '0;
            dig_s1_q   <= '0;
            dig_s2_q   <= '0;
            fsm_q      <= S_INIT;
            dir_up_q   <= 1'b0;
            state_q    <= OP_HOLD;
            rd0_q      <= '0;
            ra_q       <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            btn_prev_q <= btn_prev_d;
            dig_s1_q   <= dig_s1_d;
            dig_s2_q   <= dig_s2_d;
            fsm_q      <= fsm_d;
            dir_up_q   <= dir_up_d;
            state_q    <= state_d;
            rd0_q      <= rd0_d;
            ra_q       <= ra_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.state = state_q;
    assign bus.rd0   = rd0_q;
    assign bus.ra    = ra_q;
    assign bus.we    = we_q;
    assign bus.cnt   = cnt_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dr_edit_ctrl.sv
// Directed bench for dr_edit_ctrl: reset/auto-load, backspace, digit entry,
// held buttons, write-back priority, address wrap and reset mid-operation.
module tb_dr_edit_ctrl;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   we_seen = 0;
    int   op_seen = 0;

    dr_edit_ctrl_if #(.AW(3)) bus ();

    dr_edit_ctrl #(.AW(3), .NDIG(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Count write strobes and op pulses as seen at the sampling edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.we) we_seen++;
            if (bus.state != 4'd0) op_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the sampling point where a non-zero op code first appears.
    task automatic wait_op(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.state != 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: bus.btn_digit = v;
            1: bus.btn_del   = v;
            2: bus.btn_down  = v;
            3: bus.btn_up    = v;
            default: bus.btn_wb = v;
        endcase
    endtask

    // Press, expect one op with given code and resulting cnt, release, settle.
    task automatic press_op(input string tag, input int b, input logic [3:0] exp_st,
                            input logic [2:0] exp_cnt);
        bit ok;
        set_btn(b, 1'b1);
        wait_op(tag, ok);
        if (ok) begin
            chk({tag, "_state"}, 32'(bus.state), 32'(exp_st));
            chk({tag, "_cnt"}, 32'(bus.cnt), 32'(exp_cnt));
        end
        set_btn(b, 1'b0);
        cyc(5);
    endtask

    task automatic digit_op(input string tag, input logic [3:0] d, input logic [2:0] exp_cnt);
        bit ok;
        bus.digit = d;
        cyc(3);
        bus.btn_digit = 1'b1;
        wait_op(tag, ok);
        if (ok) begin
            chk({tag, "_state"}, 32'(bus.state), 32'd3);
            chk({tag, "_rd0"}, 32'(bus.rd0), 32'(d));
            chk({tag, "_cnt"}, 32'(bus.cnt), 32'(exp_cnt));
        end
        bus.btn_digit = 1'b0;
        cyc(5);
    endtask

    // Up/down: ADDR pulse with the new address, then LOAD on the next cycle.
    task automatic addr_op(input string tag, input int b, input logic [2:0] exp_ra);
        bit ok;
        set_btn(b, 1'b1);
        wait_op(tag, ok);
        if (ok) begin
            chk({tag, "_addr_state"}, 32'(bus.state), 32'd5);
            chk({tag, "_ra"}, 32'(bus.ra), 32'(exp_ra));
            @(negedge clk);
            chk({tag, "_load_state"}, 32'(bus.state), 32'd1);
            chk({tag, "_load_cnt"}, 32'(bus.cnt), 32'd4);
            chk({tag, "_load_ra"}, 32'(bus.ra), 32'(exp_ra));
        end
        set_btn(b, 1'b0);
        cyc(5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  ops0;
        int  we0;
        bit  ok;
        bus.btn_digit = 1'b0;
        bus.btn_del   = 1'b0;
        bus.btn_wb    = 1'b0;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.digit     = 4'd0;

        // Reset state
        cyc(3);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_ra", 32'(bus.ra), 32'd0);
        chk("rst_cnt", 32'(bus.cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_rd0", 32'(bus.rd0), 32'd0);

        // Reset release: auto-load of register 0 two cycles later
        rstn = 1'b1;
        @(negedge clk);
        chk("init_p1_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        chk("init_p2_state", 32'(bus.state), 32'd1);
        chk("init_p2_ra", 32'(bus.ra), 32'd0);
        chk("init_p2_cnt", 32'(bus.cnt), 32'd4);
        @(negedge clk);
        chk("init_p3_state", 32'(bus.state), 32'd0);
        chk("init_p3_busy", 32'(bus.busy), 32'd0);
        cyc(2);

        // Exact latency: input before posedge k, op code after posedge k+3
        bus.btn_del = 1'b1;
        cyc(3);
        chk("lat_k2_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        chk("lat_k3_state", 32'(bus.state), 32'd4);
        chk("lat_k3_cnt", 32'(bus.cnt), 32'd3);
        chk("lat_k3_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("lat_k4_state", 32'(bus.state), 32'd0);
        bus.btn_del = 1'b0;
        cyc(5);

        press_op("del2", 1, 4'd4, 3'd2);
        press_op("del3", 1, 4'd4, 3'd1);
        press_op("del4", 1, 4'd4, 3'd0);

        // Backspace on empty DR: nothing issued
        ops0 = op_seen;
        we0  = we_seen;
        bus.btn_del = 1'b1;
        cyc(8);
        bus.btn_del = 1'b0;
        cyc(3);
        chk("del_empty_ops", 32'(op_seen - ops0), 32'd0);
        chk("del_empty_we", 32'(we_seen - we0), 32'd0);
        chk("del_empty_cnt", 32'(bus.cnt), 32'd0);

        // Digit entry and saturation
        digit_op("digA", 4'hA, 3'd1);
        digit_op("digB", 4'hB, 3'd2);
        digit_op("digC", 4'hC, 3'd3);
        digit_op("digD", 4'hD, 3'd4);
        digit_op("dig1_sat", 4'h1, 3'd4);

        // Held button yields a single op
        ops0 = op_seen;
        bus.btn_del = 1'b1;
        cyc(15);
        bus.btn_del = 1'b0;
        cyc(4);
        chk("held_ops", 32'(op_seen - ops0), 32'd1);
        chk("held_cnt", 32'(bus.cnt), 32'd3);

        // Write-back wins over a simultaneous digit press
        ops0 = op_seen;
        we0  = we_seen;
        bus.digit     = 4'h7;
        cyc(3);
        bus.btn_wb    = 1'b1;
        bus.btn_digit = 1'b1;
        wait_op("wb", ok);
        if (ok) begin
            chk("wb_state", 32'(bus.state), 32'd2);
            chk("wb_we", 32'(bus.we), 32'd1);
            chk("wb_ra", 32'(bus.ra), 32'd0);
            @(negedge clk);
            chk("wb_we_after", 32'(bus.we), 32'd0);
        end
        bus.btn_wb    = 1'b0;
        bus.btn_digit = 1'b0;
        cyc(6);
        chk("wb_ops", 32'(op_seen - ops0), 32'd1);
        chk("wb_we_count", 32'(we_seen - we0), 32'd1);
        chk("wb_cnt", 32'(bus.cnt), 32'd3);
        chk("wb_rd0_held", 32'(bus.rd0), 32'd1);

        // Address wrap in both directions
        addr_op("down_wrap", 2, 3'd7);
        addr_op("up_wrap", 3, 3'd0);
        addr_op("up_1", 3, 3'd1);

        // Reset during ADDR
        bus.btn_up = 1'b1;
        wait_op("rst_mid", ok);
        if (ok) chk("rst_mid_pre_state", 32'(bus.state), 32'd5);
        rstn = 1'b0;
        bus.btn_up = 1'b0;
        #1;
        chk("rst_mid_state", 32'(bus.state), 32'd0);
        chk("rst_mid_ra", 32'(bus.ra), 32'd0);
        chk("rst_mid_cnt", 32'(bus.cnt), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        cyc(2);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_rel_p1_state", 32'(bus.state), 32'd0);
        @(negedge clk);
        chk("rst_rel_p2_state", 32'(bus.state), 32'd1);
        chk("rst_rel_p2_ra", 32'(bus.ra), 32'd0);
        chk("rst_rel_p2_cnt", 32'(bus.cnt), 32'd4);
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dr_edit_ctrl.md
Name: dr_edit_ctrl

Overview:
- Sequencer for the 16-bit data register (DR) and the register file in the hex-entry datapath.
- Turns raw button/switch inputs into one-cycle DR operation codes, register-file addressing and write strobes.
- Lets the operator browse registers, enter or delete hex digits in DR, and write DR back to the file.
- Sits between the board I/O and the DR/register-file pair; owns all of DR's `state` input.

Parameters:
- AW, 3, register-file address width (2^AW registers).
- NDIG, 4, DR width in hex digits; digit-count saturation value.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- btn_digit  in  1  raw level; rising edge = enter digit.
- digit  in  4  raw hex digit value (switches).
- btn_del  in  1  raw level; rising edge = backspace.
- btn_wb  in  1  raw level; rising edge = write DR to register file.
- btn_up  in  1  raw level; rising edge = address +1.
- btn_down  in  1  raw level; rising edge = address -1.
- state  out  4  DR op code: 0 hold, 1 load rd1, 2 write (DR holds), 3 shift-in rd0, 4 shift-out, 5 address update (DR holds).
- rd0  out  4  latched digit fed to DR.
- ra  out  AW  register-file read/write address.
- we  out  1  register-file write enable; write data is DR out, taken externally.
- cnt  out  3  valid digits currently in DR, range 0..NDIG.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset: rstn low forces all outputs to 0 immediately: state=0, rd0=0, ra=0, we=0, cnt=0, busy=0. Synchronizers and edge registers clear; FSM enters INIT. This also applies mid-operation; any pending op is abandoned.
- Input conditioning:
  - Each btn_* and the digit bus pass through 2-FF synchronizers.
  - A rising edge is detected from sync stage 2 versus its previous value.
  - An input rising before posedge k produces its state code at posedge k+3.
- All outputs are registered. Each op code is a one-cycle pulse, then state returns to 0.
- FSM states: INIT, IDLE, LOAD, WRITE, SHIFT_IN, SHIFT_OUT, ADDR.
- INIT: one cycle after reset release -> LOAD. Auto-loads register 0 into DR.
- IDLE: busy=0, state=0. On a detected edge, select one op by priority: wb > up > down > del > digit. Lower-priority edges in the same cycle are dropped.
- WRITE (from wb): state=2, we=1 for exactly one cycle at address ra; cnt unchanged -> IDLE.
- ADDR (from up/down): state=5; ra <= ra±1 modulo 2^AW (7+1 -> 0, 0-1 -> 7) -> LOAD.
- LOAD: state=1 with the new ra already stable, so DR samples rd1 of the updated address; cnt <= NDIG -> IDLE.
- SHIFT_IN (from digit): rd0 <= synchronized digit at the same edge state becomes 3; cnt <= min(cnt+1, NDIG). At cnt=NDIG the shift still occurs (oldest digit discarded) -> IDLE.
- SHIFT_OUT (from del): if cnt=0, no op is issued (state stays 0, go straight to IDLE). Otherwise state=4, cnt <= cnt-1 -> IDLE.
- Edges detected while busy=1 are dropped, never queued.
- we is high only in WRITE. rd0 holds its value until the next SHIFT_IN.
- Held buttons generate one op only; a new op needs a release and re-press.

Test Plan:
- Reset release, no inputs -> state=1 exactly one cycle, 2 cycles after release; ra=0, cnt=4, then state=0, busy=0.
- Four digit presses A,B,C,D after a del×4 -> cnt sequence 3,2,1,0 then 1,2,3,4; state=3 each time with rd0=A,B,C,D; 5th press digit 1 -> state=3, cnt stays 4.
- btn_del with cnt=0 -> state stays 0, cnt=0, no pulse on we.
- btn_up at ra=7 -> state=5 then state=1 on the next cycle; ra=0, cnt=4. btn_down at ra=0 -> ra=7.
- btn_wb and btn_digit rising in the same cycle -> only state=2 with we=1 for one cycle at current ra; digit dropped, cnt unchanged.
- Assert rstn low during ADDR -> outputs 0 immediately (ra=0); after release -> INIT/LOAD of register 0.
